fft_frame_assembler: RTL
========================

Name: fft_frame_assembler

Overview:
- Parametrised input framer for the streaming FFT datapath. Sits between the sample source and the FFT core.
- Accepts PAR complex samples per beat and assembles N_POINTS samples into one frame.
- Sign-extends each sample from INPUT_WIDTH to OUTPUT_WIDTH and presents the whole frame in parallel with a valid/ready handshake.
- Generalises the fixed 16-point, 4-lane interface to any point count, lane count and width, and adds backpressure, drop detection and optional bit-reversed ordering.

Parameters:
- N_POINTS, 16, samples per frame; power of two, >= PAR
- PAR, 4, complex samples per input beat; power of two, divides N_POINTS
- INPUT_WIDTH, 16, bits per real/imag component at input
- OUTPUT_WIDTH, 16, bits per component at output; must be >= INPUT_WIDTH
- Derived: BEATS = N_POINTS/PAR; CNT_W = max(1, clog2(BEATS))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_sync  in  1  synchronous reset, active-high
- i_valid  in  1  input beat valid
- i_ready  out  1  block can accept a beat
- i_data  in  [PAR][2] x INPUT_WIDTH  samples; [k][0]=real, [k][1]=imag; signed
- o_valid  out  1  frame valid
- o_ready  in  1  downstream accepts frame
- o_data  out  [N_POINTS][2] x OUTPUT_WIDTH  assembled frame, signed
- o_beat_cnt  out  CNT_W  beats accepted into the current frame
- o_drop  out  1  sticky: a beat arrived with i_valid=1 while i_ready=0

Behaviour:
- Reset (rst_sync=1 at a clk edge) overrides everything that cycle:
  - state=COLLECT, i_ready=1, o_valid=0, o_beat_cnt=0, o_drop=0, o_data=all zeros.
  - Reset mid-frame discards partial frame and any held output frame.
- Beat accepted when i_valid & i_ready.
  - Sample k of beat b is written to frame index n = b*PAR + k.
  - Each component is sign-extended to OUTPUT_WIDTH; no rounding, no saturation.
- Storage:
  - Collection buffer of N_POINTS samples.
  - Separate output register driving o_data.
  - o_data holds stable while o_valid=1 and o_ready=0.
- Output slot free at an edge iff o_valid=0 or o_ready=1.
- State COLLECT (i_ready=1):
  - Accepted beat with o_beat_cnt < BEATS-1: write beat, o_beat_cnt++.
  - Accepted beat with o_beat_cnt = BEATS-1 and slot free: buffer plus current beat loaded into output register; o_valid=1 next cycle; o_beat_cnt=0.
  - Latency: last beat at edge t gives o_valid at t+1.
  - Accepted last beat with slot busy: write beat, o_beat_cnt=0, go to FULL.
- State FULL (i_ready=0):
  - When slot free, transfer buffer to output register, o_valid=1, return to COLLECT.
  - i_ready=1 from the following cycle.
- Frame handshake:
  - o_valid falls after an o_valid & o_ready edge unless a new frame loads at that same edge.
  - If a new frame loads at that edge, o_valid stays 1 with the new data (back-to-back, no bubble).
- i_ready is registered and is a function of state only.
- With slot free, continuous input at full rate sustains one frame per BEATS cycles with no stall.
- o_drop:
  - Set on any edge with i_valid=1 and i_ready=0; the beat is ignored.
  - Cleared only by reset.
- i_data is ignored when i_valid=0.

Optional Feature:
- Macro: FFT_FRAME_BITREV_EN.
- Defined: sample n is written to output position bitrev(n) over log2(N_POINTS) bits, feeding a DIT core directly. Example, N_POINTS=16: input n=1 appears at o_data[8].
- Undefined: natural order, o_data[n] = sample n.
- Handshake and timing are identical either way.

Test Plan:
- Reset then 4 beats, N_POINTS=16, PAR=4, i_data[k] = (4b+k, -(4b+k)), o_ready=1:
  - o_valid=1 exactly one cycle after beat 3.
  - o_data[n] = (n, -n), sign-extended.
  - o_beat_cnt sequence 0,1,2,3,0.
- 3 back-to-back frames, i_valid held high, o_ready=1 -> i_ready never drops; o_valid pulses every 4 cycles; frames carry correct data.
- o_ready=0 while 2 frames are sent:
  - Frame 1 held stable on o_data.
  - After frame 2's last beat, i_ready=0.
  - Raise o_ready one cycle: o_valid stays 1, o_data switches to frame 2, i_ready=1 next cycle.
- i_valid=1 while i_ready=0 -> o_drop=1 and stays 1; that beat does not appear in any frame; rst_sync clears o_drop.
- Assert rst_sync after 2 beats with a held frame -> next cycle o_valid=0, o_beat_cnt=0, i_ready=1; next full frame contains only post-reset data.
- INPUT_WIDTH=8, OUTPUT_WIDTH=12, sample 0x80 -> output 0xF80; with FFT_FRAME_BITREV_EN, input n=3 appears at o_data[12].

Source files
------------

// File: rtl/fft_frame_assembler.sv
// Input framer for the streaming FFT: packs N_POINTS/PAR beats of PAR complex samples into one
// sign-extended parallel frame with valid/ready. Define FFT_FRAME_BITREV_EN for bit-reversed output order.

module fft_frame_sext #(
  parameter int IW = 16,
  parameter int OW = 16
) (
  input  logic [1:0][IW-1:0] din,
  output logic [1:0][OW-1:0] dout
);
  always_comb begin
    for (int c = 0; c < 2; c++) dout[c] = OW'($signed(din[c]));
  end
endmodule

module fft_frame_assembler #(
  parameter int N_POINTS     = 16,
  parameter int PAR          = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16,
  localparam int BEATS = N_POINTS / PAR,
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                           clk,
  input  logic                                           rst_sync,
  input  logic                                           i_valid,
  output logic                                           i_ready,
  input  logic [PAR-1:0][1:0][INPUT_WIDTH-1:0]           i_data,
  output logic                                           o_valid,
  input  logic                                           o_ready,
  output logic [N_POINTS-1:0][1:0][OUTPUT_WIDTH-1:0]     o_data,
  output logic [CNT_W-1:0]                               o_beat_cnt,
  output logic                                           o_drop
);
  localparam int IDX_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

  typedef enum logic {COLLECT, FULL} state_t;
  typedef logic [N_POINTS-1:0][1:0][OUTPUT_WIDTH-1:0] frame_t;

  state_t state, state_nxt;
  frame_t frm_q, frm_w;
  logic [PAR-1:0][1:0][OUTPUT_WIDTH-1:0] ext;
  logic accept, last_beat, slot_free;
  logic load_out, wr_buf, cnt_inc, cnt_clr;

  for (genvar k = 0; k < PAR; k++) begin : g_lane
    fft_frame_sext #(.IW(INPUT_WIDTH), .OW(OUTPUT_WIDTH)) u_sext (
      .din  (i_data[k]),
      .dout (ext[k])
    );
  end

  // Buffer slot for lane k of beat b; the reorder is applied on write so o_data is a plain copy.
  function automatic logic [IDX_W-1:0] frame_pos(input logic [CNT_W-1:0] b, input int k);
    logic [IDX_W-1:0] n;
    n = IDX_W'(int'(b) * PAR + k);
`ifdef FFT_FRAME_BITREV_EN
    begin
      logic [IDX_W-1:0] r;
      for (int i = 0; i < IDX_W; i++) r[i] = n[IDX_W-1-i];
      return r;
    end
`else
    return n;
`endif
  endfunction

  assign i_ready   = (state == COLLECT);
  assign accept    = i_valid && i_ready;
  assign last_beat = (o_beat_cnt == CNT_W'(BEATS - 1));
  assign slot_free = !o_valid || o_ready;

  // Buffer contents with the current beat merged in; lets the last beat bypass straight to o_data.
  always_comb begin
    frm_w = frm_q;
    if (accept) begin
      for (int k = 0; k < PAR; k++) frm_w[frame_pos(o_beat_cnt, k)] = ext[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) state <= COLLECT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    wr_buf    = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (!last_beat) begin
            wr_buf  = 1'b1;
            cnt_inc = 1'b1;
          end else if (slot_free) begin
            load_out = 1'b1;
            cnt_clr  = 1'b1;
          end else begin
            wr_buf    = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (slot_free) begin
          load_out  = 1'b1;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      frm_q      <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_beat_cnt <= '0;
      o_drop     <= 1'b0;
    end else begin
      if (wr_buf)   frm_q  <= frm_w;
      if (load_out) o_data <= frm_w;
      if (load_out)     o_valid <= 1'b1;
      else if (o_ready) o_valid <= 1'b0;
      if (cnt_clr)      o_beat_cnt <= '0;
      else if (cnt_inc) o_beat_cnt <= o_beat_cnt + CNT_W'(1);
      if (i_valid && !i_ready) o_drop <= 1'b1;
    end
  end
endmodule
